// File: rtl/rx_packet_fifo.sv
// rx_packet_fifo
// Store-and-forward receive buffer between the MAC receive stream and the
// sniffer controller. Incoming beats are framed into packets. Errored or
// overflowing packets are dropped by rewinding the write pointer. The read
// side only sees packets that have been fully committed.
//
// Ports
//   clk, n_rst         clock, async active-low reset
//   in_data/in_valid   receive beat (byte 0 in [31:24]); no backpressure
//   in_sop/in_eop      packet framing
//   in_empty           unused bytes in the eop beat
//   in_error           MAC error flag on this beat
//   rdreq              read request; data appears on rddata the next cycle
//   rddata             registered read data
//   rdempty            no committed beats left to read
//   wrfull             physical storage full
//   eop / error        one-cycle pulse: packet committed / dropped
//   pkt_bytes          byte length of the last committed packet
//   overflow           sticky: a drop was caused by a full FIFO
module rx_packet_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [1:0]            in_empty,
  input  logic                  in_error,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] rddata,
  output logic                  rdempty,
  output logic                  wrfull,
  output logic                  eop,
  output logic                  error,
  output logic [15:0]           pkt_bytes,
  output logic                  overflow
);
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int AW    = PTR_W - 1;

  typedef enum logic [1:0] {WAIT_SOP, RECEIVE, DROP} state_t;

  state_t                r_state, w_state_nxt;
  logic [PTR_W-1:0]      r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [15:0]           r_beats;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rddata;
  logic                  r_eop, r_error, r_overflow;
  logic [15:0]           r_pkt_bytes;

  logic [PTR_W-1:0] w_fill;
  logic             w_rdempty, w_wrfull, w_rd;
  logic             w_wr, w_commit, w_drop, w_ovf;
  logic [15:0]      w_beats_nxt;
  logic [17:0]      w_len_raw;
  logic [15:0]      w_len;

  assign w_fill    = r_wr_ptr - r_rd_ptr;
  assign w_rdempty = (r_rd_ptr == r_commit_ptr);
  assign w_wrfull  = (w_fill == PTR_W'(DEPTH));
  assign w_rd      = rdreq && !w_rdempty;

  // Beat count including the current beat; a sop beat restarts the count.
  assign w_beats_nxt = (r_state == WAIT_SOP) ? 16'd1 :
                       (r_beats == 16'hFFFF) ? r_beats : r_beats + 16'd1;
  assign w_len_raw   = {w_beats_nxt, 2'b00} - 18'(in_empty);
  assign w_len       = (|w_len_raw[17:16]) ? 16'hFFFF : w_len_raw[15:0];

  // In WAIT_SOP wr_ptr always equals commit_ptr, so commit_ptr doubles as
  // the start of the packet being received and the rewind target on a drop.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    w_ovf       = 1'b0;
    case (r_state)
      WAIT_SOP: begin
        if (in_valid && in_sop) begin
          // A sop arriving while committed data fills the FIFO would
          // overwrite unread beats, so it is treated as an overflow drop.
          if (in_error || w_wrfull) begin
            w_drop      = 1'b1;
            w_ovf       = w_wrfull;
            w_state_nxt = in_eop ? WAIT_SOP : DROP;
          end else begin
            w_wr = 1'b1;
            if (in_eop) w_commit    = 1'b1;
            else        w_state_nxt = RECEIVE;
          end
        end
      end
      RECEIVE: begin
        if (in_valid) begin
          if (in_sop || in_error || w_wrfull) begin
            w_drop      = 1'b1;
            w_ovf       = w_wrfull;
            w_state_nxt = in_eop ? WAIT_SOP : DROP;
          end else begin
            w_wr = 1'b1;
            if (in_eop) begin
              w_commit    = 1'b1;
              w_state_nxt = WAIT_SOP;
            end
          end
        end
      end
      DROP: begin
        if (in_valid && in_eop) w_state_nxt = WAIT_SOP;
      end
      default: w_state_nxt = WAIT_SOP;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= WAIT_SOP;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_beats      <= '0;
      r_rddata     <= '0;
      r_eop        <= 1'b0;
      r_error      <= 1'b0;
      r_pkt_bytes  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_eop   <= w_commit;
      r_error <= w_drop;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_beats  <= w_beats_nxt;
      end
      if (w_drop)   r_wr_ptr     <= r_commit_ptr;
      if (w_commit) begin
        r_commit_ptr <= r_wr_ptr + PTR_W'(1);
        r_pkt_bytes  <= w_len;
      end
      if (w_ovf) r_overflow <= 1'b1;
      if (w_rd) begin
        r_rddata <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
  end

  assign rddata    = r_rddata;
  assign rdempty   = w_rdempty;
  assign wrfull    = w_wrfull;
  assign eop       = r_eop;
  assign error     = r_error;
  assign pkt_bytes = r_pkt_bytes;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_rx_packet_fifo.sv
// Directed bench for rx_packet_fifo (DEPTH=8): framing, commit length,
// error drop, overflow drop, read/write across pointer wrap, mid-packet reset.
module tb_rx_packet_fifo;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_error = 1'b0;
  logic [1:0]  in_empty = '0;
  logic        rdreq = 1'b0;
  logic [31:0] rddata;
  logic        rdempty, wrfull, eop, error, overflow;
  logic [15:0] pkt_bytes;

  int n_chk = 0;
  int n_err = 0;

  rx_packet_fifo #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty), .in_error(in_error),
    .rdreq(rdreq), .rddata(rddata), .rdempty(rdempty), .wrfull(wrfull),
    .eop(eop), .error(error), .pkt_bytes(pkt_bytes), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Drive one beat for one cycle (inputs change on the falling edge).
  task automatic beat(input logic [31:0] d, input logic s, input logic e,
                      input logic [1:0] emp, input logic er);
    @(negedge clk);
    rdreq    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_empty = emp;
    in_error = er;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_error = 1'b0;
    rdreq    = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] exp);
    @(negedge clk);
    in_valid = 1'b0;
    rdreq    = 1'b1;
    @(negedge clk);
    rdreq = 1'b0;
    chk(tag, rddata, exp);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got_q[$];
    int          err_seen;
    int          full_seen;

    reset_dut();
    chk("rst_rdempty", 32'(rdempty), 32'd1);
    chk("rst_rddata", rddata, 32'd0);
    chk("rst_wrfull", 32'(wrfull), 32'd0);
    chk("rst_eop", 32'(eop), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_pkt_bytes", 32'(pkt_bytes), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // 3-beat packet, in_empty=1 -> 11 bytes
    beat(32'h1111_1111, 1, 0, 2'd0, 0);
    beat(32'h2222_2222, 0, 0, 2'd0, 0);
    beat(32'h3333_3333, 0, 1, 2'd1, 0);
    chk("p3_no_early_eop", 32'(eop), 32'd0);
    chk("p3_still_empty", 32'(rdempty), 32'd1);
    idle();
    chk("p3_eop", 32'(eop), 32'd1);
    chk("p3_bytes", 32'(pkt_bytes), 32'd11);
    chk("p3_rdempty", 32'(rdempty), 32'd0);
    idle();
    chk("p3_eop_once", 32'(eop), 32'd0);
    read_chk("p3_rd0", 32'h1111_1111);
    read_chk("p3_rd1", 32'h2222_2222);
    read_chk("p3_rd2", 32'h3333_3333);
    chk("p3_drained", 32'(rdempty), 32'd1);

    // 1-beat packet, in_empty=3 -> 1 byte
    beat(32'h4444_4444, 1, 1, 2'd3, 0);
    idle();
    chk("p1_eop", 32'(eop), 32'd1);
    chk("p1_bytes", 32'(pkt_bytes), 32'd1);
    read_chk("p1_rd0", 32'h4444_4444);
    chk("p1_drained", 32'(rdempty), 32'd1);
    read_chk("p1_rd_empty_holds", 32'h4444_4444);

    // 4-beat packet with error on beat 2, then a good 2-beat packet
    beat(32'hA1A1_A1A1, 1, 0, 2'd0, 0);
    beat(32'hA2A2_A2A2, 0, 0, 2'd0, 0);
    beat(32'hA3A3_A3A3, 0, 0, 2'd0, 1);
    beat(32'hA4A4_A4A4, 0, 1, 2'd0, 0);
    chk("perr_error", 32'(error), 32'd1);
    chk("perr_no_eop", 32'(eop), 32'd0);
    idle();
    chk("perr_error_once", 32'(error), 32'd0);
    chk("perr_rdempty", 32'(rdempty), 32'd1);
    chk("perr_bytes_kept", 32'(pkt_bytes), 32'd1);
    chk("perr_no_ovf", 32'(overflow), 32'd0);
    beat(32'hB1B1_B1B1, 1, 0, 2'd0, 0);
    beat(32'hB2B2_B2B2, 0, 1, 2'd0, 0);
    idle();
    chk("pb_eop", 32'(eop), 32'd1);
    chk("pb_bytes", 32'(pkt_bytes), 32'd8);
    read_chk("pb_rd0", 32'hB1B1_B1B1);
    read_chk("pb_rd1", 32'hB2B2_B2B2);
    chk("pb_drained", 32'(rdempty), 32'd1);

    // 20 x 3-beat packets with continuous reads across pointer wraps
    err_seen  = 0;
    full_seen = 0;
    fork
      begin
        for (int p = 0; p < 20; p++)
          for (int b = 0; b < 3; b++)
            beat(32'hC000_0000 + 32'(p*3 + b), b == 0, b == 2, 2'd0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
      end
      begin
        logic pend;
        pend = 1'b0;
        for (int c = 0; c < 300 && got_q.size() < 60; c++) begin
          @(negedge clk);
          if (pend) got_q.push_back(rddata);
          if (error)  err_seen++;
          if (wrfull) full_seen++;
          rdreq = 1'b1;
          pend  = !rdempty;
        end
        @(negedge clk);
        rdreq = 1'b0;
      end
    join
    chk("wrap_count", 32'(got_q.size()), 32'd60);
    for (int i = 0; i < got_q.size() && i < 60; i++)
      chk($sformatf("wrap_rd%0d", i), got_q[i], 32'hC000_0000 + 32'(i));
    chk("wrap_no_error", 32'(err_seen), 32'd0);
    chk("wrap_no_full", 32'(full_seen), 32'd0);
    chk("wrap_bytes", 32'(pkt_bytes), 32'd12);
    chk("wrap_drained", 32'(rdempty), 32'd1);

    // Overflow: 10-beat packet into 8 entries, no reads
    reset_dut();
    for (int i = 0; i < 9; i++)
      beat(32'hD000_0000 + 32'(i), i == 0, 0, 2'd0, 0);
    chk("ovf_wrfull", 32'(wrfull), 32'd1);
    chk("ovf_no_err_yet", 32'(error), 32'd0);
    beat(32'hD000_0009, 0, 1, 2'd0, 0);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_rewound", 32'(wrfull), 32'd0);
    chk("ovf_rdempty", 32'(rdempty), 32'd1);
    idle();
    chk("ovf_error_once", 32'(error), 32'd0);
    chk("ovf_no_eop", 32'(eop), 32'd0);
    beat(32'hE1E1_E1E1, 1, 0, 2'd0, 0);
    beat(32'hE2E2_E2E2, 0, 1, 2'd2, 0);
    idle();
    chk("ovf_next_eop", 32'(eop), 32'd1);
    chk("ovf_next_bytes", 32'(pkt_bytes), 32'd6);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    read_chk("ovf_rd0", 32'hE1E1_E1E1);
    read_chk("ovf_rd1", 32'hE2E2_E2E2);
    chk("ovf_drained", 32'(rdempty), 32'd1);

    // Reset mid-packet with 2 committed beats unread
    beat(32'hF1F1_F1F1, 1, 0, 2'd0, 0);
    beat(32'hF2F2_F2F2, 0, 1, 2'd0, 0);
    beat(32'hF3F3_F3F3, 1, 0, 2'd0, 0);
    chk("mr_has_data", 32'(rdempty), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    n_rst    = 1'b0;
    #1;
    chk("mr_rdempty", 32'(rdempty), 32'd1);
    chk("mr_rddata", rddata, 32'd0);
    chk("mr_pkt_bytes", 32'(pkt_bytes), 32'd0);
    chk("mr_overflow", 32'(overflow), 32'd0);
    chk("mr_eop", 32'(eop), 32'd0);
    chk("mr_error", 32'(error), 32'd0);
    chk("mr_wrfull", 32'(wrfull), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    read_chk("mr_rd_ignored0", 32'd0);
    read_chk("mr_rd_ignored1", 32'd0);
    chk("mr_still_empty", 32'(rdempty), 32'd1);
    beat(32'h5A5A_5A5A, 1, 1, 2'd0, 0);
    idle();
    chk("mr_new_eop", 32'(eop), 32'd1);
    chk("mr_new_bytes", 32'(pkt_bytes), 32'd4);
    read_chk("mr_new_rd", 32'h5A5A_5A5A);
    chk("mr_new_drained", 32'(rdempty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
